// File: rtl/tmds_align_ctrl.sv
`timescale 1ns/1ps
// Per-channel TMDS word-alignment FSMs sharing one round-robin bitslip arbiter; all outputs registered.
// Macro ALIGN_AUTO_RETRY_EN: FAIL becomes a one-cycle flag followed by a fresh hunt instead of a terminal state.
module tmds_align_ctrl #(
   parameter int unsigned ERR_THRESH    = 32,
   parameter int unsigned SETTLE_CYCLES = 16,
   parameter int unsigned LOCK_WINDOW   = 65535,
   parameter int unsigned MAX_SLIPS     = 20
) (
   input  logic       clk_1x_in,
   input  logic       reset_in,
   input  logic       enable_in,
   input  logic [2:0] ch_err_in,
   output logic [2:0] slip_out,
   output logic [2:0] ch_locked_out,
   output logic       all_locked_out,
   output logic [2:0] align_fail_out
);

   localparam int NCH = 3;
   localparam int SW  = $clog2(SETTLE_CYCLES + 2);
   localparam int KW  = $clog2(MAX_SLIPS + 2);

   localparam logic [15:0]   ERR_TH  = 16'(ERR_THRESH);
   localparam logic [15:0]   LOCK_W  = 16'(LOCK_WINDOW);
   localparam logic [SW-1:0] SETTLE_N = SW'(SETTLE_CYCLES);
   localparam logic [KW-1:0] SLIP_MAX = KW'(MAX_SLIPS);

   typedef enum logic [2:0] {
      ST_HUNT   = 3'd0,
      ST_REQ    = 3'd1,
      ST_SETTLE = 3'd2,
      ST_LOCKED = 3'd3,
      ST_FAIL   = 3'd4
   } state_e;

   state_e [NCH-1:0]          state_q, state_d;
   logic   [NCH-1:0][15:0]    err_cnt_q, err_cnt_d;
   logic   [NCH-1:0][15:0]    clean_cnt_q, clean_cnt_d;
   logic   [NCH-1:0][SW-1:0]  settle_cnt_q, settle_cnt_d;
   logic   [NCH-1:0][KW-1:0]  slip_cnt_q, slip_cnt_d;
   logic   [1:0]              ptr_q, ptr_d;
   logic   [NCH-1:0]          slip_q, slip_d;
   logic   [NCH-1:0]          locked_q, locked_d;
   logic   [NCH-1:0]          fail_q, fail_d;
   logic                      all_locked_q, all_locked_d;
   logic   [NCH-1:0]          grant;
   logic   [1:0]              cand0, cand1, cand2;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [1:0] next_ch(input logic [1:0] v);
      return (v == 2'd2) ? 2'd0 : v + 2'd1;
   endfunction

   // Round-robin: search from the pointer, first channel waiting in REQ wins.
   always_comb begin
      grant = '0;
      cand0 = ptr_q;
      cand1 = next_ch(cand0);
      cand2 = next_ch(cand1);
      if (state_q[cand0] == ST_REQ)      grant[cand0] = 1'b1;
      else if (state_q[cand1] == ST_REQ) grant[cand1] = 1'b1;
      else if (state_q[cand2] == ST_REQ) grant[cand2] = 1'b1;
   end

   always_comb begin
      ptr_d = ptr_q;
      for (int i = 0; i < NCH; i++) begin
         state_d[i]      = state_q[i];
         err_cnt_d[i]    = err_cnt_q[i];
         clean_cnt_d[i]  = clean_cnt_q[i];
         settle_cnt_d[i] = settle_cnt_q[i];
         slip_cnt_d[i]   = slip_cnt_q[i];
         slip_d[i]       = 1'b0;
         locked_d[i]     = locked_q[i];
         fail_d[i]       = fail_q[i];

         if (grant[i]) ptr_d = next_ch(2'(i));

         case (state_q[i])
            ST_HUNT: begin
               if (ch_err_in[i]) begin
                  err_cnt_d[i]   = sat_inc16(err_cnt_q[i]);
                  clean_cnt_d[i] = '0;
               end else begin
                  clean_cnt_d[i] = sat_inc16(clean_cnt_q[i]);
               end
               if (err_cnt_d[i] >= ERR_TH) begin
                  state_d[i] = ST_REQ;
               end else if (clean_cnt_d[i] >= LOCK_W) begin
                  state_d[i]     = ST_LOCKED;
                  locked_d[i]    = 1'b1;
                  err_cnt_d[i]   = '0;
                  clean_cnt_d[i] = '0;
                  slip_cnt_d[i]  = '0;
               end
            end
            ST_REQ: begin
               if (grant[i]) begin
                  err_cnt_d[i]    = '0;
                  clean_cnt_d[i]  = '0;
                  settle_cnt_d[i] = '0;
                  // One more slip would exceed the budget: give up without pulsing.
                  if (slip_cnt_q[i] >= SLIP_MAX) begin
                     state_d[i] = ST_FAIL;
                     fail_d[i]  = 1'b1;
                  end else begin
                     state_d[i]    = ST_SETTLE;
                     slip_d[i]     = 1'b1;
                     slip_cnt_d[i] = slip_cnt_q[i] + KW'(1);
                  end
               end
            end
            ST_SETTLE: begin
               if (settle_cnt_q[i] == SETTLE_N) state_d[i] = ST_HUNT;
               else                             settle_cnt_d[i] = settle_cnt_q[i] + SW'(1);
            end
            ST_LOCKED: begin
               if (ch_err_in[i]) begin
                  err_cnt_d[i]   = sat_inc16(err_cnt_q[i]);
                  clean_cnt_d[i] = '0;
               end else begin
                  clean_cnt_d[i] = sat_inc16(clean_cnt_q[i]);
               end
               if (err_cnt_d[i] >= ERR_TH) begin
                  state_d[i]     = ST_HUNT;
                  locked_d[i]    = 1'b0;
                  err_cnt_d[i]   = '0;
                  clean_cnt_d[i] = '0;
                  slip_cnt_d[i]  = '0;
               end else if (clean_cnt_d[i] >= LOCK_W) begin
                  err_cnt_d[i]   = '0;
                  clean_cnt_d[i] = '0;
               end
            end
            ST_FAIL: begin
`ifdef ALIGN_AUTO_RETRY_EN
               state_d[i]    = ST_HUNT;
               fail_d[i]     = 1'b0;
               slip_cnt_d[i] = '0;
`else
               fail_d[i]     = 1'b1;
`endif
            end
            default: state_d[i] = ST_HUNT;
         endcase

         if (!enable_in) begin
            state_d[i]      = ST_HUNT;
            err_cnt_d[i]    = '0;
            clean_cnt_d[i]  = '0;
            settle_cnt_d[i] = '0;
            slip_cnt_d[i]   = '0;
            slip_d[i]       = 1'b0;
            locked_d[i]     = 1'b0;
            fail_d[i]       = 1'b0;
         end
      end
      if (!enable_in) ptr_d = 2'd0;
      all_locked_d = &locked_d;
   end

   always_ff @(posedge clk_1x_in or posedge reset_in) begin
      if (reset_in) begin
         for (int i = 0; i < NCH; i++) state_q[i] <= ST_HUNT;
         err_cnt_q    <= '0;
         clean_cnt_q  <= '0;
         settle_cnt_q <= '0;
         slip_cnt_q   <= '0;
         ptr_q        <= 2'd0;
         slip_q       <= '0;
         locked_q     <= '0;
         fail_q       <= '0;
         all_locked_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         err_cnt_q    <= err_cnt_d;
         clean_cnt_q  <= clean_cnt_d;
         settle_cnt_q <= settle_cnt_d;
         slip_cnt_q   <= slip_cnt_d;
         ptr_q        <= ptr_d;
         slip_q       <= slip_d;
         locked_q     <= locked_d;
         fail_q       <= fail_d;
         all_locked_q <= all_locked_d;
      end
   end

   assign slip_out       = slip_q;
   assign ch_locked_out  = locked_q;
   assign all_locked_out = all_locked_q;
   assign align_fail_out = fail_q;

endmodule

// File: tb/tb_tmds_align_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for tmds_align_ctrl: random and directed stimulus against a behavioural model.
module tb_tmds_align_ctrl;

   localparam int ET = 4;
   localparam int ST = 8;
   localparam int LW = 100;
   localparam int MS = 3;

   logic       clk_1x_in;
   logic       reset_in;
   logic       enable_in;
   logic [2:0] ch_err_in;
   logic [2:0] slip_out;
   logic [2:0] ch_locked_out;
   logic       all_locked_out;
   logic [2:0] align_fail_out;

   tmds_align_ctrl #(
      .ERR_THRESH(ET), .SETTLE_CYCLES(ST), .LOCK_WINDOW(LW), .MAX_SLIPS(MS)
   ) dut (
      .clk_1x_in(clk_1x_in), .reset_in(reset_in), .enable_in(enable_in),
      .ch_err_in(ch_err_in), .slip_out(slip_out), .ch_locked_out(ch_locked_out),
      .all_locked_out(all_locked_out), .align_fail_out(align_fail_out)
   );

   initial clk_1x_in = 1'b0;
   always #5 clk_1x_in = ~clk_1x_in;

   typedef struct { int cyc; logic [9:0] v; } exp_t;
   typedef struct { int cyc; logic [2:0] v; } slip_t;

   exp_t  exp_q[$];
   slip_t slip_log[$];
   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;

   // Behavioural model: counts, a settle countdown and "waiting for a slip" flags.
   int       m_err[3], m_clean[3], m_slips[3], m_settle[3];
   bit [2:0] m_wait, m_lock, m_fail, m_slip;
   int       m_ptr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [9:0] out_vec();
      return {slip_out, ch_locked_out, all_locked_out, align_fail_out};
   endfunction

   task automatic model_clear();
      for (int c = 0; c < 3; c++) begin
         m_err[c] = 0; m_clean[c] = 0; m_slips[c] = 0; m_settle[c] = 0;
      end
      m_wait = '0; m_lock = '0; m_fail = '0; m_slip = '0; m_ptr = 0;
   endtask

   task automatic model_step(input logic [2:0] e, input logic en);
      int winner;
      if (!en) begin
         model_clear();
         return;
      end
      winner = -1;
      for (int k = 0; k < 3; k++) begin
         int c;
         c = (m_ptr + k) % 3;
         if (winner < 0 && m_wait[c]) winner = c;
      end
      m_slip = '0;
      for (int c = 0; c < 3; c++) begin
         if (m_fail[c]) begin
`ifdef ALIGN_AUTO_RETRY_EN
            m_fail[c] = 1'b0;
            m_slips[c] = 0;
`endif
         end else if (m_wait[c]) begin
            if (winner == c) begin
               m_wait[c] = 1'b0; m_err[c] = 0; m_clean[c] = 0;
               if (m_slips[c] + 1 > MS) m_fail[c] = 1'b1;
               else begin
                  m_slips[c]++;
                  m_slip[c] = 1'b1;
                  m_settle[c] = ST + 1;
               end
            end
         end else if (m_settle[c] > 0) begin
            m_settle[c]--;
         end else begin
            if (e[c]) begin
               if (m_err[c] < 65535) m_err[c]++;
               m_clean[c] = 0;
            end else if (m_clean[c] < 65535) m_clean[c]++;
            if (!m_lock[c]) begin
               if (m_err[c] >= ET) m_wait[c] = 1'b1;
               else if (m_clean[c] >= LW) begin
                  m_lock[c] = 1'b1; m_err[c] = 0; m_clean[c] = 0; m_slips[c] = 0;
               end
            end else begin
               if (m_err[c] >= ET) begin
                  m_lock[c] = 1'b0; m_err[c] = 0; m_clean[c] = 0; m_slips[c] = 0;
               end else if (m_clean[c] >= LW) begin
                  m_err[c] = 0; m_clean[c] = 0;
               end
            end
         end
      end
      if (winner >= 0) m_ptr = (winner + 1) % 3;
   endtask

   task automatic step(input logic [2:0] e, input logic en);
      exp_t x;
      ch_err_in = e;
      enable_in = en;
      @(posedge clk_1x_in);
      cyc++;
      model_step(e, en);
      x.cyc = cyc;
      x.v = {m_slip, m_lock, &m_lock, m_fail};
      exp_q.push_back(x);
      #1;
   endtask

   task automatic sync_mon();
      @(negedge clk_1x_in);
      #1;
   endtask

   task automatic check_slip(input string name, input int idx, input int at, input logic [2:0] v);
      if (idx < slip_log.size()) begin
         check({name, " cycle"}, slip_log[idx].cyc, at);
         check({name, " bits"}, {29'd0, slip_log[idx].v}, {29'd0, v});
      end else begin
         check({name, " present"}, idx, slip_log.size());
      end
   endtask

   // Monitor: every registered output word is compared against the model's prediction.
   always @(negedge clk_1x_in) begin
      if (exp_q.size() > 0) begin
         exp_t  x;
         slip_t s;
         x = exp_q.pop_front();
         check($sformatf("scoreboard cyc %0d", x.cyc), {22'd0, out_vec()}, {22'd0, x.v});
         if (slip_out != 3'b000) begin
            s.cyc = x.cyc;
            s.v = slip_out;
            slip_log.push_back(s);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      logic [2:0] fail_after;
`ifdef ALIGN_AUTO_RETRY_EN
      fail_after = 3'b000;
`else
      fail_after = 3'b100;
`endif
      reset_in = 1'b1;
      enable_in = 1'b1;
      ch_err_in = 3'b000;
      model_clear();
      #12;
      check("reset outputs", {22'd0, out_vec()}, 32'd0);
      reset_in = 1'b0;

      // Lock after LW clean cycles, then lose ch1 after ET errors.
      repeat (LW - 1) step(3'b000, 1'b1);
      check("lock before window", {29'd0, ch_locked_out}, 32'd0);
      step(3'b000, 1'b1);
      check("lock at window", {29'd0, ch_locked_out}, 32'h7);
      check("all_locked at window", {31'd0, all_locked_out}, 32'd1);
      repeat (ET - 1) step(3'b010, 1'b1);
      check("lock holds below thresh", {29'd0, ch_locked_out}, 32'h7);
      step(3'b010, 1'b1);
      check("ch1 lost lock", {29'd0, ch_locked_out}, 32'h5);
      check("all_locked dropped", {31'd0, all_locked_out}, 32'd0);

      // Continuous ch0 errors: slips every 14 cycles, then FAIL on the 4th grant.
      step(3'b000, 1'b0);
      sync_mon();
      slip_log.delete();
      base = cyc;
      repeat (47) step(3'b001, 1'b1);
      sync_mon();
      check("A slip count", slip_log.size(), 3);
      check_slip("A slip0", 0, base + 5, 3'b001);
      check_slip("A slip1", 1, base + 19, 3'b001);
      check_slip("A slip2", 2, base + 33, 3'b001);
      check("A fail raised", {29'd0, align_fail_out}, 32'h1);

      // All three channels request together: slips in order 0, 1, 2.
      step(3'b000, 1'b0);
      sync_mon();
      slip_log.delete();
      base = cyc;
      repeat (8) step(3'b111, 1'b1);
      sync_mon();
      check("B slip count", slip_log.size(), 3);
      check_slip("B ch0", 0, base + 5, 3'b001);
      check_slip("B ch1", 1, base + 6, 3'b010);
      check_slip("B ch2", 2, base + 7, 3'b100);

      // Continuous ch2 errors: three slips, then FAIL behaviour depends on retry macro.
      step(3'b000, 1'b0);
      sync_mon();
      slip_log.delete();
      base = cyc;
      repeat (47) step(3'b100, 1'b1);
      sync_mon();
      check("D slip count", slip_log.size(), 3);
      check_slip("D slip2", 2, base + 33, 3'b100);
      check("D fail raised", {29'd0, align_fail_out}, 32'h4);
      step(3'b100, 1'b1);
      check("D fail next cycle", {29'd0, align_fail_out}, {29'd0, fail_after});
      repeat (5) step(3'b100, 1'b1);
      sync_mon();
`ifdef ALIGN_AUTO_RETRY_EN
      check("D retry slip count", slip_log.size(), 4);
      check_slip("D retry slip", 3, base + 53, 3'b100);
`else
      check("D sticky slip count", slip_log.size(), 3);
      check("D sticky fail", {29'd0, align_fail_out}, 32'h4);
`endif

      // enable_in dropped while ch0 settles, then hunting resumes.
      step(3'b000, 1'b0);
      repeat (7) step(3'b001, 1'b1);
      step(3'b001, 1'b0);
      check("E outputs cleared", {22'd0, out_vec()}, 32'd0);
      sync_mon();
      slip_log.delete();
      base = cyc;
      repeat (6) step(3'b001, 1'b1);
      sync_mon();
      check("E resume slip count", slip_log.size(), 1);
      check_slip("E resume slip", 0, base + 5, 3'b001);

      // Asynchronous reset while a slip pulse is on the output.
      step(3'b000, 1'b0);
      repeat (5) step(3'b001, 1'b1);
      check("F slip before reset", {29'd0, slip_out}, 32'h1);
      exp_q.delete();
      #2;
      reset_in = 1'b1;
      #1;
      check("F slip cleared async", {29'd0, slip_out}, 32'd0);
      repeat (2) begin
         @(posedge clk_1x_in);
         #1;
         check("F no slip in reset", {22'd0, out_vec()}, 32'd0);
      end
      reset_in = 1'b0;
      model_clear();

      // Random phases with per-channel error rates and occasional enable drops.
      for (int p = 0; p < 16; p++) begin
         int rate[3];
         for (int c = 0; c < 3; c++) rate[c] = $urandom_range(0, 3);
         for (int n = 0; n < 150; n++) begin
            logic [2:0] e;
            logic en;
            for (int c = 0; c < 3; c++) begin
               case (rate[c])
                  0:       e[c] = 1'b0;
                  1:       e[c] = ($urandom_range(0, 63) == 0);
                  2:       e[c] = ($urandom_range(0, 3) == 0);
                  default: e[c] = ($urandom_range(0, 1) == 0);
               endcase
            end
            en = ($urandom_range(0, 299) != 0);
            step(e, en);
         end
      end

      sync_mon();
      check("scoreboard drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
